// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - Port addresses, scan codes and frame FSM states shared by the PS/2 keyboard path.
package teclado_pkg;

    localparam logic [7:0] PORT_TECLADO_ADDR = 8'h0a;
    localparam logic [7:0] PORT_DATO_ADDR    = 8'h0b;
    localparam logic [7:0] PORT_ESTADO_ADDR  = 8'h0c;

    localparam logic [7:0] SC_EXT = 8'he0;
    localparam logic [7:0] SC_BRK = 8'hf0;

    // Codes the keyboard decoder on PORT_TECLADO_ADDR turns into control flags.
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_F4    = 8'h0c;
    localparam logic [7:0] SC_F5    = 8'h03;
    localparam logic [7:0] SC_F12   = 8'h07;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6b;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATOS  = 2'd1,
        PARADA = 2'd2
    } frame_state_e;

endpackage

// File: rtl/ps2_rx_teclado_if.sv
// rtl/ps2_rx_teclado_if.sv - PicoBlaze port bus between the processor and the keyboard receiver.
interface ps2_rx_teclado_if;
    logic [7:0] port_ID;
    logic       read_strobe;
    logic [7:0] dato;
    logic [7:0] estado;
    logic       listo;
    logic       rx_done;

    modport master (
        output port_ID, read_strobe,
        input  dato, estado, listo, rx_done
    );

    modport slave (
        input  port_ID, read_strobe,
        output dato, estado, listo, rx_done
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 synchroniser, clock glitch filter, frame FSM and timeout; PS2_PARITY_CHECK_EN enables parity rejection.
module ps2_frame_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic [7:0] data_o,
    output logic       rx_done_o,
    output logic       par_err_o
);
    import teclado_pkg::*;

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    logic [1:0]          c_sync_q, d_sync_q;
    logic [FILT_LEN-1:0] filt_q;
    logic                fclk_q, fclk_prev_q;
    frame_state_e        state_q;
    logic [3:0]          cnt_q;
    logic [8:0]          sh_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                fall, d_bit, par_odd, tmo_hit;

    assign fall    = fclk_prev_q & ~fclk_q;
    assign d_bit   = d_sync_q[1];
    assign par_odd = ^sh_q;
    assign tmo_hit = (tmo_q == TMO_LIM);

    // Idle line level is high, so the synchroniser and filter reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q    <= 2'b11;
            d_sync_q    <= 2'b11;
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 9'd0;
            tmo_q       <= '0;
            data_o      <= 8'd0;
            rx_done_o   <= 1'b0;
            par_err_o   <= 1'b0;
        end else begin
            c_sync_q    <= {c_sync_q[0], ps2c_i};
            d_sync_q    <= {d_sync_q[0], ps2d_i};
            filt_q      <= {filt_q[FILT_LEN-2:0], c_sync_q[1]};
            if (&filt_q)
                fclk_q <= 1'b1;
            else if (~|filt_q)
                fclk_q <= 1'b0;
            fclk_prev_q <= fclk_q;
            rx_done_o   <= 1'b0;
            par_err_o   <= 1'b0;

            if (fall || state_q == IDLE)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TMO_W'(1);

            case (state_q)
                IDLE: begin
                    if (fall && !d_bit) begin
                        state_q <= DATOS;
                        cnt_q   <= 4'd0;
                    end
                end
                DATOS: begin
                    if (fall) begin
                        sh_q <= {d_bit, sh_q[8:1]};
                        if (cnt_q == 4'd8)
                            state_q <= PARADA;
                        else
                            cnt_q <= cnt_q + 4'd1;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                PARADA: begin
                    if (fall) begin
                        state_q   <= IDLE;
                        data_o    <= sh_q[7:0];
                        rx_done_o <= d_bit & (par_odd | ~PAR_CHK);
                        par_err_o <= d_bit & ~par_odd & PAR_CHK;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_teclado.sv
// rtl/ps2_rx_teclado.sv - PS/2 keyboard receiver with break/extended filter and PicoBlaze holding register; honours PS2_PARITY_CHECK_EN.
module ps2_rx_teclado
    import teclado_pkg::*;
#(
    parameter logic [7:0] PORT_DATO   = PORT_DATO_ADDR,
    parameter logic [7:0] PORT_ESTADO = PORT_ESTADO_ADDR,
    parameter int         FILT_LEN    = 8,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2c,
    input  logic              ps2d,
    ps2_rx_teclado_if.slave   bus
);

    logic [7:0] rx_byte;
    logic       rx_done, par_err;
    logic       brk_q, ext_q, brk_d, ext_d;
    logic [7:0] dato_q;
    logic       ext_lat_q, listo_q, sobre_q, err_par_q;
    logic       store, rd_dato, rd_est;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .ps2c_i    (ps2c),
        .ps2d_i    (ps2d),
        .data_o    (rx_byte),
        .rx_done_o (rx_done),
        .par_err_o (par_err)
    );

    always_comb begin
        rd_dato = bus.read_strobe && (bus.port_ID == PORT_DATO);
        rd_est  = bus.read_strobe && (bus.port_ID == PORT_ESTADO);
        brk_d   = brk_q;
        ext_d   = ext_q;
        store   = 1'b0;
        if (rx_done) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                store = 1'b1;
                ext_d = 1'b0;
            end
        end
    end

    // A store in the same cycle as a data read keeps listo set and is not an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            dato_q    <= 8'd0;
            ext_lat_q <= 1'b0;
            listo_q   <= 1'b0;
            sobre_q   <= 1'b0;
            err_par_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
            ext_q <= ext_d;
            if (store) begin
                dato_q    <= rx_byte;
                ext_lat_q <= ext_q;
            end
            listo_q   <= store | (listo_q & ~rd_dato);
            sobre_q   <= (store & listo_q & ~rd_dato) | (sobre_q & ~rd_est);
            err_par_q <= par_err | (err_par_q & ~rd_est);
        end
    end

    assign bus.dato    = dato_q;
    assign bus.estado  = {4'b0000, err_par_q, ext_lat_q, sobre_q, listo_q};
    assign bus.listo   = listo_q;
    assign bus.rx_done = rx_done;

endmodule

// File: tb/tb_ps2_rx_teclado.sv
// tb/tb_ps2_rx_teclado.sv - Directed and randomized bench for ps2_rx_teclado against a scan-code reference model.
module tb_ps2_rx_teclado;
    import teclado_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    ps2_rx_teclado_if bus_if ();

    ps2_rx_teclado #(
        .PORT_DATO   (8'h0b),
        .PORT_ESTADO (8'h0c),
        .FILT_LEN    (8),
        .TIMEOUT_CYC (20000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int rx_cnt = 0;

    logic [7:0] m_dato;
    logic       m_listo, m_sobre, m_ext, m_err, m_brk, m_extf;
    int         m_rx;

    always @(negedge clk) if (bus_if.rx_done) rx_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_dato = 8'd0; m_listo = 1'b0; m_sobre = 1'b0; m_ext = 1'b0;
        m_err = 1'b0; m_brk = 1'b0; m_extf = 1'b0;
    endtask

    // Scan-code rules: E0 marks extended, F0 starts a break, the byte after F0 is swallowed.
    task automatic model_frame(input logic [7:0] b, input bit bad);
`ifdef PS2_PARITY_CHECK_EN
        if (bad) begin
            m_err = 1'b1;
            return;
        end
`endif
        m_rx++;
        if (b == 8'he0) m_extf = 1'b1;
        else if (b == 8'hf0) m_brk = 1'b1;
        else if (m_brk) begin
            m_brk = 1'b0; m_extf = 1'b0;
        end else begin
            if (m_listo) m_sobre = 1'b1;
            m_dato = b; m_ext = m_extf; m_extf = 1'b0; m_listo = 1'b1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        repeat (15) @(negedge clk);
        ps2c = 1'b0;
        repeat (30) @(negedge clk);
        ps2c = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~(^b) ^ bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2d = 1'b1;
        repeat (10) @(negedge clk);
        model_frame(b, bad);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dato"}, bus_if.dato, m_dato);
        chk({tag, ".estado"}, bus_if.estado, {4'b0, m_err, m_ext, m_sobre, m_listo});
        chk({tag, ".listo"}, bus_if.listo, m_listo);
        chk({tag, ".rxcnt"}, rx_cnt, m_rx);
    endtask

    task automatic pb_read(input logic [7:0] addr);
        @(negedge clk);
        bus_if.port_ID = addr;
        bus_if.read_strobe = 1'b1;
        #1;
        if (addr == 8'h0b) chk("rd_dato", bus_if.dato, m_dato);
        if (addr == 8'h0c) chk("rd_estado", bus_if.estado, {4'b0, m_err, m_ext, m_sobre, m_listo});
        @(negedge clk);
        bus_if.read_strobe = 1'b0;
        bus_if.port_ID = 8'h00;
        if (addr == 8'h0b) m_listo = 1'b0;
        if (addr == 8'h0c) begin m_sobre = 1'b0; m_err = 1'b0; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bit bad;
        bus_if.port_ID = 8'h00;
        bus_if.read_strobe = 1'b0;
        model_reset();
        m_rx = 0;
        repeat (5) @(negedge clk);
        check_outputs("reset");
        chk("reset.rx_done", bus_if.rx_done, 1'b0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        send_frame(8'h05, 1'b0);
        check_outputs("f1");
        chk("f1.estado01", bus_if.estado, 8'h01);
        pb_read(8'h0b);

        send_frame(8'he0, 1'b0); send_frame(8'h75, 1'b0);
        check_outputs("ext_up");
        chk("ext_up.bit2", bus_if.estado[2], 1'b1);
        send_frame(8'he0, 1'b0); send_frame(8'hf0, 1'b0); send_frame(8'h75, 1'b0);
        check_outputs("brk_up");
        pb_read(8'h0b);
        check_outputs("brk_up.read");

        send_frame(8'h06, 1'b0); send_frame(8'h04, 1'b0);
        check_outputs("ovr");
        chk("ovr.estado03", bus_if.estado, 8'h03);
        pb_read(8'h0c);
        check_outputs("ovr.clr");
        pb_read(8'h0b);

        send_frame(8'h0c, 1'b1);
        check_outputs("par");
        pb_read(8'h0c);
        pb_read(8'h0b);

        // Partial frame: start bit plus four data bits, then silence past the timeout.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (21000) @(negedge clk);
        check_outputs("tmo");
        send_frame(8'h07, 1'b0);
        check_outputs("tmo.next");
        pb_read(8'h0b);

        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h03, 1'b0);
        check_outputs("glitch");

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();
        check_outputs("midrst");
        chk("midrst.rx_done", bus_if.rx_done, 1'b0);
        ps2c = 1'b1; ps2d = 1'b1;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h72, 1'b0);
        check_outputs("postrst");

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'he0;
            else if (r == 1) b = 8'hf0;
            else b = 8'($urandom_range(1, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
            check_outputs("rnd");
            r = $urandom_range(0, 3);
            if (r == 0) pb_read(8'h0b);
            else if (r == 1) pb_read(8'h0c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_rx_teclado.md
# ps2_rx_teclado

PS/2 keyboard receiver and scan-code filter feeding the PicoBlaze keyboard path. It deserialises PS/2 frames and removes break sequences (`F0 xx`). It flags extended prefixes (`E0`) and holds one make-code for the processor. The processor reads the code, then writes it to the keyboard decoder on port `8'h0a`, which maps F1–F5, F12 and the arrow keys to control flags.

## Interface
Parameters:
- `PORT_DATO`, `8'h0b`: PicoBlaze input port that returns the held scan code. Reading it clears `listo`.
- `PORT_ESTADO`, `8'h0c`: input port that returns the status byte. Reading it clears `sobrecarga`.
- `FILT_LEN`, `8`: ps2c glitch-filter length, in clk cycles.
- `TIMEOUT_CYC`, `20000`: maximum clk cycles between falling edges within a frame before the frame is abandoned.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `ps2c` input 1: PS/2 clock, asynchronous.
- `ps2d` input 1: PS/2 data, asynchronous.
- `port_ID` input 8: PicoBlaze port address.
- `read_strobe` input 1: PicoBlaze read strobe, one cycle.
- `dato` output 8: held scan code.
- `estado` output 8: status byte `{4'b0, err_par, ext, sobrecarga, listo}`.
- `listo` output 1: a code is held and unread.
- `rx_done` output 1: one-cycle pulse for every accepted frame, before filtering.

## Operation
- **Synchronisation:** ps2c and ps2d each pass through 2 flip-flops.
- **Glitch filter:** synchronised ps2c enters a `FILT_LEN` shift register. The filtered clock goes to 1 when all taps are 1 and to 0 when all taps are 0; otherwise it holds.
- **Edge detect:** a falling edge is filtered ps2c going 1→0. ps2d (synchronised) is sampled in that same cycle.
- **Frame FSM:**
  - `IDLE`: moves to `DATOS` on a falling edge with ps2d=0 (start bit). A falling edge with ps2d=1 is ignored.
  - `DATOS`: shifts in 8 data bits LSB-first, then the parity bit, counting 0..8. After the 9th bit it moves to `PARADA`.
  - `PARADA`: on a falling edge, the frame is valid if stop=1 and parity is odd. A valid frame pulses `rx_done` and hands the byte to the filter. The FSM returns to `IDLE` in every case.
- **Timeout:** a counter resets on every falling edge. If it reaches `TIMEOUT_CYC` in `DATOS` or `PARADA`, the FSM returns to `IDLE` and drops the partial frame silently.
- **Filter stage** (2 flags, `brk` and `ext`):
  - Byte `E0`: set `ext`; nothing is stored.
  - Byte `F0`: set `brk`; nothing is stored.
  - Any other byte with `brk`=1: discard it and clear `brk` and `ext`.
  - Any other byte with `brk`=0: store it in `dato`, latch `ext` into `estado[2]`, clear `ext`, and set `listo`.
- **Holding register:**
  - If a new code arrives while `listo`=1, the new code overwrites `dato` and `sobrecarga` is set (sticky).
  - `read_strobe` with `port_ID`=`PORT_DATO` clears `listo` on the next edge.
  - `read_strobe` with `port_ID`=`PORT_ESTADO` clears `sobrecarga` and `err_par`.
  - If a store and a data read occur in the same cycle, the store wins: `listo` stays 1 and `sobrecarga` is not set.
- **Reset values:** `dato`=0, `estado`=0, `listo`=0, `rx_done`=0. All FSMs go to `IDLE` and both flags clear. Reset mid-frame discards the frame.

## Timing
- Falling edge of raw ps2c to detected edge: 2 cycles of synchronisation plus `FILT_LEN` cycles of filtering.
- Stop-bit edge → `rx_done`: 1 cycle later.
- `rx_done` → `dato`/`listo` updated: 1 cycle later.
- `estado` and `dato` are registered and combinationally stable for the PicoBlaze read cycle.
- Filtered pulses shorter than `FILT_LEN` cycles are never seen as edges.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: frames with even parity are dropped and set sticky `err_par` (`estado[3]`).
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is shifted in but ignored; such frames are accepted and `err_par` is tied to 0.

## Structure
- A shared package `teclado_pkg` holds:
  - the port addresses `8'h0a`/`8'h0b`/`8'h0c`;
  - the prefix constants `E0` and `F0`;
  - the F-key and arrow scan codes shared with the keyboard decoder;
  - the frame FSM state encoding.
- One sub-module, `ps2_frame_rx`, contains the synchroniser, filter, frame FSM and timeout, and outputs a byte plus `rx_done`. The top level contains the filter stage and the port interface.

## Test plan
- Frame `05` (F1) with odd parity → `rx_done` pulses, `dato`=`8'h05`, `listo`=1, `estado`=`8'h01`.
- Sequence `E0 75`, then `E0 F0 75` → one stored code `75` with `estado[2]`=1; the break sequence stores nothing, and `listo` stays 1 until the PicoBlaze reads port `0b`.
- Two make-codes `06` then `04` with no read between them → `dato`=`04`, `estado`=`8'h03`. A read of port `0c` then clears `sobrecarga`.
- Frame `0c` with even parity → with `PS2_PARITY_CHECK_EN`: no store and `estado[3]`=1. Without it: `dato`=`0c`.
- 4 data bits followed by silence longer than `TIMEOUT_CYC` → no store. A following clean frame `07` → `dato`=`07`.
- 3-cycle ps2c glitch while `IDLE`, then `reset` low mid-frame → no edge is detected from the glitch, all outputs return to 0, and the next frame decodes correctly.
